// File: rtl/board_mem_scan_reader_if.sv
// rtl/board_mem_scan_reader_if.sv - Wishbone classic bus bundle used by the board memory scan reader
//
// Purpose : carries one Wishbone classic read/write channel between a
//           master and the board memory slave.
// Signals : cyc, stb, we, adr[ADDR_W-1:0] driven by the master;
//           dat_s2m[DATA_W-1:0], ack driven by the slave.
interface wishbone_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_s2m;
    logic              ack;

    modport master (
        output cyc,
        output stb,
        output we,
        output adr,
        input  dat_s2m,
        input  ack
    );

    modport slave (
        input  cyc,
        input  stb,
        input  we,
        input  adr,
        output dat_s2m,
        output ack
    );
endinterface

// File: rtl/board_mem_scan_reader.sv
// rtl/board_mem_scan_reader.sv - Wishbone classic read master that scans the active board region
//
// Purpose : on a start pulse, reads every cell of the active_size x active_size
//           board region in row-major order (address stride BOARD_SIZE),
//           streams each cell with its coordinates, counts mine cells and
//           aborts with a sticky error if the slave fails to acknowledge.
// Ports   : clk, rst (sync, active-high)
//           start, active_size       - scan request and board edge (latched on start)
//           rd_wb                    - Wishbone master: cyc/stb/we/adr out, dat_s2m/ack in
//           busy, done, err          - scan status (done is a one-cycle pulse, err sticky)
//           cell_valid, cell_x/y,    - one-cycle strobe per cell with captured data
//           cell_data
//           mine_count               - mines found so far, held after done
module board_mem_scan_reader #(
    parameter int BOARD_SIZE  = 16,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int MINE_BIT    = 0,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [$clog2(BOARD_SIZE+1)-1:0]             active_size,
    wishbone_if.master                                  rd_wb,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err,
    output logic                                        cell_valid,
    output logic [$clog2(BOARD_SIZE)-1:0]               cell_x,
    output logic [$clog2(BOARD_SIZE)-1:0]               cell_y,
    output logic [DATA_W-1:0]                           cell_data,
    output logic [$clog2(BOARD_SIZE*BOARD_SIZE+1)-1:0]  mine_count
);

    localparam int SZ_W  = $clog2(BOARD_SIZE + 1);
    localparam int XY_W  = $clog2(BOARD_SIZE);
    localparam int CNT_W = $clog2(BOARD_SIZE * BOARD_SIZE + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [SZ_W-1:0]   L_MAX_SIZE = SZ_W'(BOARD_SIZE);
    localparam logic [ADDR_W-1:0] L_STRIDE   = ADDR_W'(BOARD_SIZE);
    localparam logic [TMO_W-1:0]  L_TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [SZ_W-1:0]     r_size;
    logic [XY_W-1:0]     r_x;
    logic [XY_W-1:0]     r_y;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_cyc;
    logic                r_stb;
    logic [ADDR_W-1:0]   r_adr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_cell_valid;
    logic [XY_W-1:0]     r_cell_x;
    logic [XY_W-1:0]     r_cell_y;
    logic [DATA_W-1:0]   r_cell_data;
    logic [CNT_W-1:0]    r_mine_count;

    logic                w_size_ok;
    logic                w_x_last;
    logic                w_last_cell;
    logic [XY_W-1:0]     w_next_x;
    logic [XY_W-1:0]     w_next_y;
    logic [ADDR_W-1:0]   w_next_adr;

    assign w_size_ok   = (active_size != '0) && (active_size <= L_MAX_SIZE);

    // Coordinates of the cell just read are compared against the latched size,
    // widened so that a full-size board (edge == BOARD_SIZE) compares correctly.
    assign w_x_last    = (SZ_W'(r_x) == r_size - SZ_W'(1));
    assign w_last_cell = w_x_last && (SZ_W'(r_y) == r_size - SZ_W'(1));
    assign w_next_x    = w_x_last ? '0 : r_x + XY_W'(1);
    assign w_next_y    = w_x_last ? r_y + XY_W'(1) : r_y;
    assign w_next_adr  = ADDR_W'(w_next_y) * L_STRIDE + ADDR_W'(w_next_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_size       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_tmo        <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_adr        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cell_valid <= 1'b0;
            r_cell_x     <= '0;
            r_cell_y     <= '0;
            r_cell_data  <= '0;
            r_mine_count <= '0;
        end else begin
            r_cell_valid <= 1'b0;
            r_done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_size       <= active_size;
                        r_mine_count <= '0;
                        r_err        <= 1'b0;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_tmo        <= '0;
                        if (w_size_ok) begin
                            r_busy  <= 1'b1;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_adr   <= '0;
                            r_state <= S_REQ;
                        end else begin
                            // Invalid edge: report straight away, never touch the bus.
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_REQ: begin
                    if (rd_wb.ack) begin
                        r_cell_valid <= 1'b1;
                        r_cell_x     <= r_x;
                        r_cell_y     <= r_y;
                        r_cell_data  <= rd_wb.dat_s2m;
                        r_mine_count <= r_mine_count + CNT_W'(rd_wb.dat_s2m[MINE_BIT]);
                        r_cyc        <= 1'b0;
                        r_stb        <= 1'b0;
                        r_tmo        <= '0;
                        r_state      <= S_GAP;
                    end else if (r_tmo == L_TMO_LAST) begin
                        // This is the ACK_TIMEOUT-th cycle without ack: abandon the scan.
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_tmo   <= '0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                S_GAP: begin
                    if (w_last_cell) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_x     <= w_next_x;
                        r_y     <= w_next_y;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_adr   <= w_next_adr;
                        r_state <= S_REQ;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_wb.cyc  = r_cyc;
    assign rd_wb.stb  = r_stb;
    assign rd_wb.we   = 1'b0;
    assign rd_wb.adr  = r_adr;

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cell_valid = r_cell_valid;
    assign cell_x     = r_cell_x;
    assign cell_y     = r_cell_y;
    assign cell_data  = r_cell_data;
    assign mine_count = r_mine_count;

endmodule

// File: tb/tb_board_mem_scan_reader.sv
// tb/tb_board_mem_scan_reader.sv - directed self-checking bench for board_mem_scan_reader
module tb_board_mem_scan_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] active_size;
    logic       busy;
    logic       done;
    logic       err;
    logic       cell_valid;
    logic [3:0] cell_x;
    logic [3:0] cell_y;
    logic [7:0] cell_data;
    logic [8:0] mine_count;

    always #5 clk = ~clk;

    wishbone_if #(.ADDR_W(8), .DATA_W(8)) wb ();

    board_mem_scan_reader #(
        .BOARD_SIZE (16),
        .DATA_W     (8),
        .ADDR_W     (8),
        .MINE_BIT   (0),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .active_size(active_size),
        .rd_wb      (wb),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cell_valid (cell_valid),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_data  (cell_data),
        .mine_count (mine_count)
    );

    // Slave model: board memory with programmable ack delay and one dead address.
    logic [7:0] mem [256];
    int         delay     = 0;
    logic       noack_en  = 1'b0;
    logic [7:0] noack_adr = 8'd0;
    int         wcnt      = 0;

    assign wb.ack     = wb.cyc && wb.stb && (wcnt >= delay) && !(noack_en && wb.adr == noack_adr);
    assign wb.dat_s2m = mem[wb.adr];

    always @(posedge clk) begin
        if (wb.cyc && wb.stb && !wb.ack) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc_cnt  = 0;
    int         s_cyc    = 0;
    int         nvalid, nack, ndone, done_at, seq_bad, stab_bad, nreq_dead;
    int         cur_size;
    logic       cyc_seen, stab_en, prev_wait;
    logic [7:0] prev_adr, last_adr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        nvalid    = 0;
        nack      = 0;
        ndone     = 0;
        done_at   = -1;
        seq_bad   = 0;
        stab_bad  = 0;
        nreq_dead = 0;
        cyc_seen  = 1'b0;
        prev_wait = 1'b0;
        prev_adr  = 8'd0;
        last_adr  = 8'd0;
    endtask

    task automatic sample();
        int ex, ey, ea;
        if (cell_valid) begin
            ex = nvalid % cur_size;
            ey = nvalid / cur_size;
            if (32'(cell_x) != ex || 32'(cell_y) != ey || cell_data != mem[ey*16 + ex]) seq_bad++;
            nvalid++;
        end
        if (wb.cyc && wb.stb && wb.ack) begin
            ea = (nack / cur_size) * 16 + (nack % cur_size);
            if (32'(wb.adr) != ea) seq_bad++;
            last_adr = wb.adr;
            nack++;
        end
        if (wb.cyc) begin
            cyc_seen = 1'b1;
            if (noack_en && wb.adr == noack_adr) nreq_dead++;
        end
        if (done) begin
            ndone++;
            done_at = cyc_cnt;
        end
        if (stab_en && prev_wait && !(wb.cyc && wb.stb && wb.adr == prev_adr)) stab_bad++;
        prev_wait = wb.cyc && wb.stb && !wb.ack;
        prev_adr  = wb.adr;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc_cnt++;
        @(negedge clk);
        sample();
    endtask

    task automatic do_start(input int size);
        active_size = 5'(size);
        start       = 1'b1;
        s_cyc       = cyc_cnt;
        tick();
        start       = 1'b0;
    endtask

    // Waits for done within a cycle budget, then lets DONE return to IDLE.
    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (ndone == 0 && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(ndone), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int k;
        rst         = 1'b1;
        start       = 1'b0;
        active_size = 5'd0;
        cur_size    = 1;
        stab_en     = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_stats();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_cyc",   32'(wb.cyc),     32'd0);
        check("rst_stb",   32'(wb.stb),     32'd0);
        check("rst_we",    32'(wb.we),      32'd0);
        check("rst_adr",   32'(wb.adr),     32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_valid", 32'(cell_valid), 32'd0);
        check("rst_mines", 32'(mine_count), 32'd0);

        // Full 16x16 scan, zero memory, immediate ack.
        clear_stats();
        cur_size = 16;
        do_start(16);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 600);
        check("t1_cells",   32'(nvalid),        32'd256);
        check("t1_seq",     32'(seq_bad),       32'd0);
        check("t1_lastadr", 32'(last_adr),      32'd255);
        check("t1_latency", 32'(done_at - s_cyc), 32'd513);
        check("t1_mines",   32'(mine_count),    32'd0);
        check("t1_err",     32'(err),           32'd0);
        check("t1_busy_end", 32'(busy),         32'd0);

        // 8x8 region with three mines; decoys outside the region and non-mine bits inside.
        mem[0]   = 8'h01;
        mem[119] = 8'h01;
        mem[83]  = 8'h01;
        mem[8]   = 8'h01;
        mem[200] = 8'h01;
        mem[5]   = 8'h80;
        mem[50]  = 8'hFE;
        clear_stats();
        cur_size = 8;
        do_start(8);
        wait_done("t2_done", 200);
        check("t2_cells",   32'(nvalid),     32'd64);
        check("t2_seq",     32'(seq_bad),    32'd0);
        check("t2_lastadr", 32'(last_adr),   32'd119);
        check("t2_mines",   32'(mine_count), 32'd3);
        check("t2_err",     32'(err),        32'd0);

        // Patterned memory for the remaining tests: odd addresses carry the mine bit.
        for (int i = 0; i < 256; i++) begin
            k = i;
            mem[i] = 8'(k) ^ 8'h5A;
        end

        // 2x2 scan with a 5-cycle ack delay; request must hold steady while waiting.
        clear_stats();
        delay    = 5;
        stab_en  = 1'b1;
        cur_size = 2;
        do_start(2);
        wait_done("t3_done", 100);
        check("t3_cells", 32'(nvalid),     32'd4);
        check("t3_stab",  32'(stab_bad),   32'd0);
        check("t3_seq",   32'(seq_bad),    32'd0);
        check("t3_mines", 32'(mine_count), 32'd2);
        check("t3_err",   32'(err),        32'd0);
        stab_en = 1'b0;
        delay   = 0;

        // Dead slave at address 17 on a 16x16 scan.
        clear_stats();
        noack_en  = 1'b1;
        noack_adr = 8'd17;
        cur_size  = 16;
        do_start(16);
        wait_done("t4_done", 300);
        check("t4_cells",   32'(nvalid),     32'd17);
        check("t4_reqcyc",  32'(nreq_dead),  32'd64);
        check("t4_err",     32'(err),        32'd1);
        check("t4_busy",    32'(busy),       32'd0);
        check("t4_cyc",     32'(wb.cyc),     32'd0);
        check("t4_mines",   32'(mine_count), 32'd8);
        noack_en = 1'b0;

        // Invalid sizes 0 and 17: no bus traffic, error, done one cycle after start.
        clear_stats();
        cur_size = 1;
        do_start(0);
        wait_done("t5a_done", 20);
        check("t5a_lat",   32'(done_at - s_cyc), 32'd1);
        check("t5a_nocyc", 32'(cyc_seen),        32'd0);
        check("t5a_err",   32'(err),             32'd1);
        clear_stats();
        do_start(17);
        wait_done("t5b_done", 20);
        check("t5b_lat",   32'(done_at - s_cyc), 32'd1);
        check("t5b_nocyc", 32'(cyc_seen),        32'd0);
        check("t5b_err",   32'(err),             32'd1);
        check("t5b_cells", 32'(nvalid),          32'd0);
        clear_stats();
        cur_size = 1;
        do_start(1);
        check("t5c_errclr", 32'(err), 32'd0);
        wait_done("t5c_done", 20);
        check("t5c_cells", 32'(nvalid),  32'd1);
        check("t5c_seq",   32'(seq_bad), 32'd0);
        check("t5c_err",   32'(err),     32'd0);

        // Extra start mid-scan is ignored; reset at cell 40 aborts silently.
        clear_stats();
        cur_size = 16;
        do_start(16);
        k = 0;
        while (nvalid < 10 && k < 200) begin
            tick();
            k++;
        end
        active_size = 5'd3;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        k = 0;
        while (nvalid < 40 && k < 200) begin
            tick();
            k++;
        end
        check("t6_reach40", 32'(nvalid),     32'd40);
        check("t6_mines40", 32'(mine_count), 32'd20);
        check("t6_seq",     32'(seq_bad),    32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_cyc",   32'(wb.cyc),     32'd0);
        check("t6_stb",   32'(wb.stb),     32'd0);
        check("t6_busy",  32'(busy),       32'd0);
        check("t6_mines", 32'(mine_count), 32'd0);
        check("t6_valid", 32'(cell_valid), 32'd0);
        cyc_seen = 1'b0;
        repeat (30) tick();
        check("t6_nodone", 32'(ndone),    32'd0);
        check("t6_idle",   32'(cyc_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/board_mem_scan_reader.md
Name: board_mem_scan_reader

Overview:
- Wishbone classic read master for the board memory. It is the read-side counterpart of the write masters that feed the write arbiter.
- On a start pulse it reads every cell of the active board region in row-major order and streams each cell out with its coordinates.
- It counts cells with the mine bit set and flags a slave that fails to acknowledge.
- Used by game logic (win check, mine recount, reveal-all on loss). It sits in the 100 MHz domain, on the same clock as the board memory.

Parameters:
BOARD_SIZE, 16, maximum board edge length; the address stride is fixed at BOARD_SIZE.
DATA_W, 8, cell data width.
ADDR_W, 8, Wishbone address width; must satisfy 2^ADDR_W >= BOARD_SIZE*BOARD_SIZE.
MINE_BIT, 0, bit index of the mine flag inside cell data.
ACK_TIMEOUT, 64, cycles to wait for ack before aborting.

Ports:
clk  in  1  system clock (100 MHz); single clock domain.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle scan request.
active_size  in  $clog2(BOARD_SIZE+1)  board edge to scan; sampled on an accepted start.
rd_wb  wishbone_if.master  -  uses cyc, stb, we, adr[ADDR_W-1:0], dat_s2m[DATA_W-1:0], ack.
busy  out  1  high from an accepted start until done.
done  out  1  one-cycle pulse at scan end (normal or abort).
err  out  1  sticky error; cleared on the next accepted start.
cell_valid  out  1  one-cycle strobe per cell read.
cell_x  out  $clog2(BOARD_SIZE)  column of cell_data.
cell_y  out  $clog2(BOARD_SIZE)  row of cell_data.
cell_data  out  DATA_W  captured dat_s2m.
mine_count  out  $clog2(BOARD_SIZE*BOARD_SIZE+1)  mines found; held after done.

Behaviour:
- Reset: all outputs 0; cyc = stb = we = 0; adr = 0; state IDLE; x = y = 0; timeout counter 0.
- States and transitions:
  - IDLE: start=1 -> latch size, clear mine_count/err/x/y, busy=1.
    - Size valid (1..BOARD_SIZE) -> REQ.
    - Size 0 or > BOARD_SIZE -> DONE with err=1. No bus cycle is issued.
  - REQ: cyc = stb = 1, we = 0, adr = y*BOARD_SIZE + x, all held stable until ack.
    - On the edge where ack=1: capture cell_data/x/y, pulse cell_valid next cycle, add 1 to mine_count if cell_data[MINE_BIT], go GAP.
    - Timeout counter increments each REQ cycle without ack. Reaching ACK_TIMEOUT -> drop cyc/stb, err=1, go DONE. No cell_valid is produced for that cell.
  - GAP: cyc = stb = 0 for exactly one cycle.
    - Advance x; x wraps at size-1 -> x=0, y+1.
    - Last cell (x = y = size-1) -> DONE; else -> REQ.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Throughput: minimum 2 cycles per cell when ack comes in the first REQ cycle. A 16x16 scan takes 512 cycles, with done one cycle after the final GAP.
- mine_count increments in the same cycle cell_valid is asserted; its final value is stable when done pulses.
- start while busy: ignored, no effect on the scan.
- ack outside REQ: ignored.
- rst mid-scan: at the next edge cyc/stb drop to 0, all outputs go to reset values, and no done pulse is produced.
- active_size changes during a scan have no effect, because the size is latched at start.
- Address stride is always BOARD_SIZE, so active_size=8 reads adr 0..7, 16..23, …, 112..119.

Test Plan:
- Size 16, all cells 0x00, slave acks in 1 cycle -> 256 cell_valid pulses, cell_x/cell_y/adr sequence correct (last adr 255), done at cycle 513 after start, mine_count=0, err=0.
- Size 8, mines at (0,0),(7,7),(3,5) -> only adr 0..7, 16..23, …, 112..119 read (64 cells), mine_count=3, done pulses once.
- Slave ack delayed 5 cycles per access, size 2 -> adr/cyc/stb stable across the wait, 4 cells output, err=0.
- Slave never acks on adr 17 (size 16) -> cyc drops after 64 cycles, err=1, done pulses, exactly 17 cell_valid pulses, busy=0.
- active_size=0 and active_size=17 -> no cyc asserted, err=1, done one cycle after start; next valid start clears err.
- Start pulse mid-scan, then rst at cell 40 -> extra start ignored; after rst cyc=0, busy=0, mine_count=0, no done pulse.
